// File: rtl/pc_seq_ctrl_if.sv
// Control bundle between the multicycle sequencer and the IR / memory port / PC_subsys.
// master = sequencer side, slave = datapath side.
interface pc_seq_ctrl_if;
   logic [15:0] IRw;
   logic        mem_ready;
   logic        step;
   logic        PCWrite;
   logic [1:0]  PCSource;
   logic        BEQCond;
   logic        BNECond;
   logic        IRWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        StackPush;
   logic        StackPop;
   logic        halted;
   logic        illegal;
   logic [2:0]  state;

   modport master (
      input  IRw, mem_ready, step,
      output PCWrite, PCSource, BEQCond, BNECond, IRWrite, MemRead, MemWrite,
             StackPush, StackPop, halted, illegal, state
   );

   modport slave (
      output IRw, mem_ready, step,
      input  PCWrite, PCSource, BEQCond, BNECond, IRWrite, MemRead, MemWrite,
             StackPush, StackPop, halted, illegal, state
   );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/HALT sequencer for the 16-bit stack processor.
// Optional single-step gating of FETCH: define PC_CTRL_STEP_EN.
module pc_seq_ctrl #(
   parameter int OPW = 4
) (
   input logic           clk,
   input logic           reset,
   pc_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      HALT   = 3'd4
   } state_t;

   localparam logic [OPW-1:0] OP_ALU   = OPW'(4'h0);
   localparam logic [OPW-1:0] OP_PUSHI = OPW'(4'h1);
   localparam logic [OPW-1:0] OP_LOAD  = OPW'(4'h2);
   localparam logic [OPW-1:0] OP_STORE = OPW'(4'h3);
   localparam logic [OPW-1:0] OP_BEQ   = OPW'(4'h4);
   localparam logic [OPW-1:0] OP_BNE   = OPW'(4'h5);
   localparam logic [OPW-1:0] OP_J     = OPW'(4'h6);
   localparam logic [OPW-1:0] OP_JR    = OPW'(4'h7);
   localparam logic [OPW-1:0] OP_HALT  = OPW'(4'hF);

   state_t         cur, nxt;
   logic [OPW-1:0] opcode;
   logic           fetch_go;
   logic           unused_ok;

   assign opcode    = bus.IRw[15 -: OPW];
   assign unused_ok = &{1'b0, bus.IRw, bus.step};

`ifdef PC_CTRL_STEP_EN
   // step_pend holds a captured step until FETCH starts; fetch_busy keeps the
   // request alive across memory wait cycles once the flag has been consumed.
   logic step_pend, fetch_busy;

   assign fetch_go = step_pend | fetch_busy;

   always_ff @(posedge clk) begin
      if (!reset) begin
         step_pend  <= 1'b0;
         fetch_busy <= 1'b0;
      end else begin
         step_pend  <= bus.step | (step_pend & (cur != FETCH));
         fetch_busy <= (cur == FETCH) & fetch_go & ~bus.mem_ready;
      end
   end
`else
   assign fetch_go = 1'b1;
`endif

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) cur <= FETCH;
      else        cur <= nxt;
   end

   // NOTE: every output and nxt gets a default first, so no path can infer a latch.
   always_comb begin
      nxt           = cur;
      bus.PCWrite   = 1'b0;
      bus.PCSource  = 2'b00;
      bus.BEQCond   = 1'b0;
      bus.BNECond   = 1'b0;
      bus.IRWrite   = 1'b0;
      bus.MemRead   = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.StackPush = 1'b0;
      bus.StackPop  = 1'b0;
      bus.halted    = 1'b0;
      bus.illegal   = 1'b0;
      bus.state     = reset ? cur : FETCH;

      // While reset is held every strobe stays low, dropping any pending request.
      if (reset) begin
         case (cur)
            FETCH: begin
               if (fetch_go) begin
                  bus.MemRead = 1'b1;
                  if (bus.mem_ready) begin
                     bus.IRWrite = 1'b1;
                     bus.PCWrite = 1'b1;
                     nxt         = DECODE;
                  end
               end
            end
            DECODE: begin
               case (opcode)
                  OP_ALU, OP_PUSHI, OP_BEQ, OP_BNE, OP_J, OP_JR: nxt = EXEC;
                  OP_LOAD, OP_STORE:                             nxt = MEM;
                  OP_HALT:                                       nxt = HALT;
                  default: begin
                     bus.illegal = 1'b1;
                     nxt         = FETCH;
                  end
               endcase
            end
            EXEC: begin
               nxt = FETCH;
               case (opcode)
                  OP_ALU: begin
                     bus.StackPop  = 1'b1;
                     bus.StackPush = 1'b1;
                  end
                  OP_PUSHI: bus.StackPush = 1'b1;
                  OP_BEQ: begin
                     bus.PCSource = 2'b01;
                     bus.BEQCond  = 1'b1;
                  end
                  OP_BNE: begin
                     bus.PCSource = 2'b01;
                     bus.BNECond  = 1'b1;
                  end
                  OP_J: begin
                     bus.PCSource = 2'b01;
                     bus.PCWrite  = 1'b1;
                  end
                  OP_JR: begin
                     bus.PCSource = 2'b10;
                     bus.PCWrite  = 1'b1;
                     bus.StackPop = 1'b1;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               case (opcode)
                  OP_LOAD: begin
                     bus.MemRead   = 1'b1;
                     bus.StackPush = bus.mem_ready;
                     if (bus.mem_ready) nxt = FETCH;
                  end
                  OP_STORE: begin
                     bus.MemWrite = 1'b1;
                     bus.StackPop = bus.mem_ready;
                     if (bus.mem_ready) nxt = FETCH;
                  end
                  default: nxt = FETCH;
               endcase
            end
            HALT:    bus.halted = 1'b1;
            default: nxt = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: per-cycle expected output words are queued as
// stimulus is driven and popped/compared at the following falling edge.
module tb_pc_seq_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   pc_seq_ctrl_if bus ();

   pc_seq_ctrl #(.OPW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

`ifdef PC_CTRL_STEP_EN
   localparam logic STEP_IDLE = 1'b1;
`else
   localparam logic STEP_IDLE = 1'b0;
`endif

   // Field order: state[2:0] halted illegal PCWrite PCSource[1:0] BEQ BNE IRWrite MemRead MemWrite Push Pop
   localparam logic [14:0] E_ZERO  = 15'b000_0_0_0_00_0_0_0_0_0_0_0;
   localparam logic [14:0] E_FETCH = 15'b000_0_0_1_00_0_0_1_1_0_0_0;
   localparam logic [14:0] E_FWAIT = 15'b000_0_0_0_00_0_0_0_1_0_0_0;
   localparam logic [14:0] E_DEC   = 15'b001_0_0_0_00_0_0_0_0_0_0_0;
   localparam logic [14:0] E_ILL   = 15'b001_0_1_0_00_0_0_0_0_0_0_0;
   localparam logic [14:0] E_J     = 15'b010_0_0_1_01_0_0_0_0_0_0_0;
   localparam logic [14:0] E_BEQ   = 15'b010_0_0_0_01_1_0_0_0_0_0_0;
   localparam logic [14:0] E_BNE   = 15'b010_0_0_0_01_0_1_0_0_0_0_0;
   localparam logic [14:0] E_ALU   = 15'b010_0_0_0_00_0_0_0_0_0_1_1;
   localparam logic [14:0] E_PUSHI = 15'b010_0_0_0_00_0_0_0_0_0_1_0;
   localparam logic [14:0] E_JR    = 15'b010_0_0_1_10_0_0_0_0_0_0_1;
   localparam logic [14:0] E_LDW   = 15'b011_0_0_0_00_0_0_0_1_0_0_0;
   localparam logic [14:0] E_LDR   = 15'b011_0_0_0_00_0_0_0_1_0_1_0;
   localparam logic [14:0] E_STW   = 15'b011_0_0_0_00_0_0_0_0_1_0_0;
   localparam logic [14:0] E_STR   = 15'b011_0_0_0_00_0_0_0_0_1_0_1;
   localparam logic [14:0] E_HALT  = 15'b100_1_0_0_00_0_0_0_0_0_0_0;

   typedef struct {
      logic        rst;
      logic        mr;
      logic [15:0] ir;
      logic        stp;
      logic [14:0] e;
   } stim_t;

   logic [14:0] sb[$];

   function automatic stim_t sv(input logic r, input logic mr, input logic [15:0] ir,
                                input logic stp, input logic [14:0] e);
      stim_t s;
      s.rst = r; s.mr = mr; s.ir = ir; s.stp = stp; s.e = e;
      return s;
   endfunction

   function automatic logic [14:0] obs();
      return {bus.state, bus.halted, bus.illegal, bus.PCWrite, bus.PCSource,
              bus.BEQCond, bus.BNECond, bus.IRWrite, bus.MemRead, bus.MemWrite,
              bus.StackPush, bus.StackPop};
   endfunction

   // Drive one cycle of inputs just after the rising edge, queue its expectation,
   // and stop at the falling edge where outputs are settled.
   task automatic apply(input stim_t s);
      @(posedge clk);
      #1;
      reset         = s.rst;
      bus.mem_ready = s.mr;
      bus.IRw       = s.ir;
      bus.step      = s.stp;
      sb.push_back(s.e);
      @(negedge clk);
   endtask

   task automatic test_reset();
      stim_t q[$];
      logic [14:0] exp;
      q.push_back(sv(1'b0, 1'b1, 16'h6fc5, STEP_IDLE, E_ZERO));
      q.push_back(sv(1'b0, 1'b1, 16'h6fc5, STEP_IDLE, E_ZERO));
`ifdef PC_CTRL_STEP_EN
      q.push_back(sv(1'b1, 1'b1, 16'h6fc5, STEP_IDLE, E_ZERO));
`endif
      q.push_back(sv(1'b1, 1'b1, 16'h6fc5, STEP_IDLE, E_FETCH));
      foreach (q[i]) begin
         apply(q[i]);
         exp = sb.pop_front();
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL test_reset[%0d]: outputs %b, expected %b", i, obs(), exp);
         end
      end
   endtask

   task automatic test_jump();
      stim_t q[$];
      logic [14:0] exp;
      q.push_back(sv(1'b1, 1'b1, 16'h6fc5, STEP_IDLE, E_DEC));
      q.push_back(sv(1'b1, 1'b1, 16'h6fc5, STEP_IDLE, E_J));
      foreach (q[i]) begin
         apply(q[i]);
         exp = sb.pop_front();
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL test_jump[%0d]: outputs %b, expected %b", i, obs(), exp);
         end
      end
   endtask

   task automatic test_branch();
      stim_t q[$];
      logic [14:0] exp;
      q.push_back(sv(1'b1, 1'b1, 16'h4010, STEP_IDLE, E_FETCH));
      q.push_back(sv(1'b1, 1'b1, 16'h4010, STEP_IDLE, E_DEC));
      q.push_back(sv(1'b1, 1'b0, 16'h4010, STEP_IDLE, E_BEQ));
      q.push_back(sv(1'b1, 1'b1, 16'h5010, STEP_IDLE, E_FETCH));
      q.push_back(sv(1'b1, 1'b1, 16'h5010, STEP_IDLE, E_DEC));
      q.push_back(sv(1'b1, 1'b1, 16'h5010, STEP_IDLE, E_BNE));
      foreach (q[i]) begin
         apply(q[i]);
         exp = sb.pop_front();
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL test_branch[%0d]: outputs %b, expected %b", i, obs(), exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t q[$];
      logic [14:0] exp;
      q.push_back(sv(1'b1, 1'b1, 16'h0123, STEP_IDLE, E_FETCH));
      q.push_back(sv(1'b1, 1'b1, 16'h0123, STEP_IDLE, E_DEC));
      q.push_back(sv(1'b1, 1'b1, 16'h0123, STEP_IDLE, E_ALU));
      q.push_back(sv(1'b1, 1'b1, 16'h1abc, STEP_IDLE, E_FETCH));
      q.push_back(sv(1'b1, 1'b1, 16'h1abc, STEP_IDLE, E_DEC));
      q.push_back(sv(1'b1, 1'b1, 16'h1abc, STEP_IDLE, E_PUSHI));
      q.push_back(sv(1'b1, 1'b1, 16'h7000, STEP_IDLE, E_FETCH));
      q.push_back(sv(1'b1, 1'b1, 16'h7000, STEP_IDLE, E_DEC));
      q.push_back(sv(1'b1, 1'b1, 16'h7000, STEP_IDLE, E_JR));
      foreach (q[i]) begin
         apply(q[i]);
         exp = sb.pop_front();
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL test_back_to_back[%0d]: outputs %b, expected %b", i, obs(), exp);
         end
      end
   endtask

   task automatic test_mem_wait();
      stim_t q[$];
      logic [14:0] exp;
      q.push_back(sv(1'b1, 1'b1, 16'h2000, STEP_IDLE, E_FETCH));
      q.push_back(sv(1'b1, 1'b0, 16'h2000, STEP_IDLE, E_DEC));
      for (int k = 0; k < 3; k++)
         q.push_back(sv(1'b1, 1'b0, 16'h2000, STEP_IDLE, E_LDW));
      q.push_back(sv(1'b1, 1'b1, 16'h2000, STEP_IDLE, E_LDR));
      q.push_back(sv(1'b1, 1'b0, 16'h2000, STEP_IDLE, E_FWAIT));
      q.push_back(sv(1'b1, 1'b1, 16'h3000, STEP_IDLE, E_FETCH));
      q.push_back(sv(1'b1, 1'b1, 16'h3000, STEP_IDLE, E_DEC));
      q.push_back(sv(1'b1, 1'b0, 16'h3000, STEP_IDLE, E_STW));
      q.push_back(sv(1'b1, 1'b1, 16'h3000, STEP_IDLE, E_STR));
      foreach (q[i]) begin
         apply(q[i]);
         exp = sb.pop_front();
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL test_mem_wait[%0d]: outputs %b, expected %b", i, obs(), exp);
         end
      end
   endtask

   task automatic test_illegal_halt();
      stim_t q[$];
      logic [14:0] exp;
      q.push_back(sv(1'b1, 1'b1, 16'h9000, STEP_IDLE, E_FETCH));
      q.push_back(sv(1'b1, 1'b1, 16'h9000, STEP_IDLE, E_ILL));
      q.push_back(sv(1'b1, 1'b1, 16'hF000, STEP_IDLE, E_FETCH));
      q.push_back(sv(1'b1, 1'b1, 16'hF000, STEP_IDLE, E_DEC));
      for (int k = 0; k < 20; k++)
         q.push_back(sv(1'b1, logic'(k % 2), 16'hF000, STEP_IDLE, E_HALT));
      q.push_back(sv(1'b0, 1'b1, 16'hF000, STEP_IDLE, E_ZERO));
      q.push_back(sv(1'b0, 1'b1, 16'hF000, STEP_IDLE, E_ZERO));
      foreach (q[i]) begin
         apply(q[i]);
         exp = sb.pop_front();
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL test_illegal_halt[%0d]: outputs %b, expected %b", i, obs(), exp);
         end
      end
   endtask

`ifdef PC_CTRL_STEP_EN
   task automatic test_step();
      stim_t q[$];
      logic [14:0] exp;
      for (int k = 0; k < 10; k++)
         q.push_back(sv(1'b1, 1'b1, 16'h0000, 1'b0, E_ZERO));
      q.push_back(sv(1'b1, 1'b1, 16'h0000, 1'b1, E_ZERO));
      q.push_back(sv(1'b1, 1'b1, 16'h0000, 1'b0, E_FETCH));
      q.push_back(sv(1'b1, 1'b1, 16'h0000, 1'b0, E_DEC));
      q.push_back(sv(1'b1, 1'b1, 16'h0000, 1'b0, E_ALU));
      for (int k = 0; k < 4; k++)
         q.push_back(sv(1'b1, 1'b1, 16'h0000, 1'b0, E_ZERO));
      foreach (q[i]) begin
         apply(q[i]);
         exp = sb.pop_front();
         vectors++;
         if (obs() !== exp) begin
            miscompares++;
            $display("FAIL test_step[%0d]: outputs %b, expected %b", i, obs(), exp);
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t, required completion before it", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.mem_ready = 1'b0;
      bus.IRw       = 16'h0000;
      bus.step      = 1'b0;
      test_reset();
      test_jump();
      test_branch();
      test_back_to_back();
      test_mem_wait();
      test_illegal_halt();
`ifdef PC_CTRL_STEP_EN
      test_step();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Multicycle control sequencer for the 16-bit stack processor. Walks each instruction through fetch, decode, execute and memory phases and drives the PC subsystem's write-enable, source-select and branch-condition strobes, plus instruction-register and memory handshake signals. Sits between the instruction register/memory port and `PC_subsys`, and is the only block that writes the PC.

## Interface
- `OPW`, 4: opcode width; opcode is `IRw[15:12]`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `IRw`  in  16  current instruction register contents.
- `mem_ready`  in  1  memory completed the current read/write this cycle.
- `step`  in  1  single-step pulse; used only with `PC_CTRL_STEP_EN`.
- `PCWrite`  out  1  unconditional PC write.
- `PCSource`  out  2  PC mux select: 00 = PC+1, 01 = branch/jump target, 10 = `aWire`.
- `BEQCond`, `BNECond`  out  1 each  conditional-write enables qualified by `zero` inside `PC_subsys`.
- `IRWrite`  out  1  latch memory data into the IR.
- `MemRead`, `MemWrite`  out  1 each  memory request strobes.
- `StackPush`, `StackPop`  out  1 each  stack-pointer update strobes.
- `halted`  out  1  controller is in HALT.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `state`  out  3  current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, EXEC 2, MEM 3, HALT 4.
- FETCH:
  - assert `MemRead`; hold until `mem_ready`.
  - In the cycle with `mem_ready`=1: `IRWrite`=1, `PCWrite`=1, `PCSource`=00, then go to DECODE.
- DECODE: one cycle, no strobes. Branch on opcode:
  - 0x0 ALU, 0x1 PUSHI, 0x4 BEQ, 0x5 BNE, 0x6 J, 0x7 JR → EXEC.
  - 0x2 LOAD, 0x3 STORE → MEM.
  - 0xF HALT → HALT.
  - Other opcodes: `illegal` pulses for one cycle → FETCH (executes as a NOP).
- EXEC, one cycle, then FETCH:
  - ALU: `StackPop`=1, `StackPush`=1.
  - PUSHI: `StackPush`=1.
  - BEQ: `PCSource`=01, `BEQCond`=1.
  - BNE: `PCSource`=01, `BNECond`=1.
  - J: `PCSource`=01, `PCWrite`=1.
  - JR: `PCSource`=10, `PCWrite`=1, `StackPop`=1.
- MEM:
  - LOAD: assert `MemRead` until `mem_ready`; `StackPush`=1 in the ready cycle.
  - STORE: assert `MemWrite` until `mem_ready`; `StackPop`=1 in the ready cycle.
  - Then FETCH.
- HALT: absorbing state; `halted`=1, all other strobes 0. Only reset leaves HALT.
- `PCWrite`, `BEQCond` and `BNECond` are never asserted in the same cycle.
- `PCSource` is 00 whenever no PC strobe is active.

## Timing
- On reset (`reset`=0 at a rising edge):
  - state = FETCH.
  - all outputs 0 (`state`=0, `halted`=0, `illegal`=0).
  - Reset applies from any state, including mid-wait in FETCH/MEM; any pending memory request is dropped.
- All outputs are decoded combinationally from the registered state and `IRw`. `mem_ready` gates the ready-cycle strobes combinationally.
- Instruction latency with zero-wait memory:
  - ALU, PUSHI, branches, jumps: 3 cycles.
  - LOAD, STORE: 3 cycles.
  - Each cycle with `mem_ready` low adds one cycle to FETCH or MEM.
- `IRw` must be stable from DECODE through the end of EXEC/MEM. The IR changes only on the FETCH ready edge.
- A branch resolves in its EXEC cycle; the PC update is visible the following cycle.
- If `mem_ready` is already high on FETCH entry, fetch completes in 1 cycle.

## Configuration
- `PC_CTRL_STEP_EN` defined:
  - FETCH issues `MemRead` only once a `step` pulse has been captured.
  - A `step` seen in any state is latched into a 1-bit pending flag. The flag clears when FETCH begins its request.
  - Reset clears the flag.
- `PC_CTRL_STEP_EN` undefined: `step` is ignored and FETCH requests immediately.

## Test plan
- Reset: `reset`=0 for 2 cycles → `state`=0, all strobes 0. Release with `mem_ready`=1 → `MemRead`=1, `IRWrite`=1, `PCWrite`=1, `PCSource`=00 in the first cycle.
- J `IRw`=16'h6fc5, zero-wait memory → EXEC cycle has `PCWrite`=1 and `PCSource`=01; next instruction fetched 3 cycles after the previous fetch.
- BEQ `IRw`=16'h4010 → EXEC has `BEQCond`=1, `PCSource`=01, `PCWrite`=0. BNE `IRw`=16'h5010 → `BNECond`=1 only.
- LOAD `IRw`=16'h2000 with `mem_ready` low for 3 MEM cycles → `MemRead` held 4 cycles; `StackPush`=1 only in the 4th; then FETCH.
- `IRw`=16'h9000 → `illegal` pulses 1 cycle in DECODE, then FETCH. `IRw`=16'hF000 → `halted`=1 stays set for 20 cycles; `reset` low → `state`=0.
- With `PC_CTRL_STEP_EN` defined: no `step` → `MemRead`=0 for 10 cycles. One `step` pulse → exactly one instruction executes, then the controller waits again.
